// File: rtl/apb_ctrl_pkg.sv
// Shared constants for the round-robin APB master: FSM state encoding and
// default bus widths / timeout used by apb_rr_master and its arbiter.
package apb_ctrl_pkg;

  localparam int AW_DEF      = 4;
  localparam int DW_DEF      = 8;
  localparam int TIMEOUT_DEF = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i,
// wrapping modulo NREQ. Returns one-hot grant, its index and any-valid.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  int j;

  // Scan from the farthest position back to ptr_i so the nearest hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req_i[j]) begin
        any_o = 1'b1;
        idx_o = IW'(j);
      end
    end
    gnt_o[idx_o] = any_o;
  end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master sharing one APB slave among NREQ requesters.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT pready-low cycles.
module apb_rr_master
  import apb_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  req_done,
  output logic             req_err,
  output logic [DW-1:0]    req_rdata,
  output logic             psel,
  output logic             penable,
  output logic             pwrite,
  output logic [AW-1:0]    paddr,
  output logic [DW-1:0]    pwdata,
  input  logic             pready,
  input  logic [DW-1:0]    prdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic            pwrite_q, pwrite_d;
  logic [NREQ-1:0] req_done_q, req_done_d;
  logic            req_err_q, req_err_d;
  logic [DW-1:0]   req_rdata_q, req_rdata_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            timeout_hit;

  // A requester is masked in the cycle its completion pulse is visible.
  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i (req & ~req_done_q),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wcnt_q, wcnt_d;

  always_comb begin
    wcnt_d = wcnt_q;
    if (state_q == ST_SETUP) begin
      wcnt_d = '0;
    end else if (state_q == ST_ACCESS && !pready) begin
      wcnt_d = wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wcnt_q <= '0;
    else      wcnt_q <= wcnt_d;
  end

  // Abort on the edge where the wait count would reach TIMEOUT.
  assign timeout_hit = (wcnt_q == CW'(TIMEOUT - 1));
`else
  assign timeout_hit = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    req_done_d  = '0;
    req_err_d   = 1'b0;
    req_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
              paddr_d  = req_addr[i*AW +: AW];
              pwdata_d = req_wdata[i*DW +: DW];
              pwrite_d = req_write[i];
            end
          end
          gidx_d  = arb_idx;
          ptr_d   = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready) begin
          req_done_d[gidx_q] = 1'b1;
          req_rdata_d        = pwrite_q ? '0 : prdata;
          state_d            = ST_IDLE;
        end else if (timeout_hit) begin
          req_done_d[gidx_q] = 1'b1;
          req_err_d          = 1'b1;
          state_d            = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      req_done_q  <= '0;
      req_err_q   <= 1'b0;
      req_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      req_done_q  <= req_done_d;
      req_err_q   <= req_err_d;
      req_rdata_q <= req_rdata_d;
    end
  end

  assign psel      = (state_q != ST_IDLE);
  assign penable   = (state_q == ST_ACCESS);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign req_done  = req_done_q;
  assign req_err   = req_err_q;
  assign req_rdata = req_rdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed plus randomized bench for apb_rr_master with a behavioural
// round-robin / APB reference model.
module tb_apb_rr_master;

  localparam int NREQ    = 4;
  localparam int AW      = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req, req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   req_done;
  logic              req_err;
  logic [DW-1:0]     req_rdata;
  logic              psel, penable, pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic              pready;
  logic [DW-1:0]     prdata;

  apb_rr_master #(
    .NREQ (NREQ), .AW (AW), .DW (DW), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_done  (req_done),
    .req_err   (req_err),
    .req_rdata (req_rdata),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pready    (pready),
    .prdata    (prdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Requester-side model state
  logic [NREQ-1:0] m_req, m_wr;
  logic [AW-1:0]   m_addr  [NREQ];
  logic [DW-1:0]   m_wdata [NREQ];
  int              ptr_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req       = m_req;
    req_write = m_wr;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW]  = m_addr[i];
      req_wdata[i*DW +: DW] = m_wdata[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int next_grant(input logic [NREQ-1:0] mask, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Serve one transfer expected for requester g; leaves time in the done cycle.
  task automatic serve(input int g, input int waits, input bit abort_xfer,
                       input bit scramble, input logic [DW-1:0] rdv);
    int n;
    int limit;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    ea = m_addr[g];
    ed = m_wdata[g];
    ew = m_wr[g];
    n  = 0;
    while (psel !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("setup_seen", {31'd0, psel}, 1);
    if (psel !== 1'b1) return;
    check("setup_bus", {penable, pwrite, paddr, req_done}, {1'b0, ew, ea, 4'b0000});
    if (ew) check("setup_pwdata", pwdata, ed);
    ptr_m = (g + 1) % NREQ;
    if (scramble) begin
      m_addr[g]  = AW'($urandom);
      m_wdata[g] = DW'($urandom);
      m_wr[g]    = ~m_wr[g];
      drive();
    end
    tick();
    limit = abort_xfer ? TIMEOUT : waits + 1;
    for (int k = 0; k < limit; k++) begin
      check("access_bus", {psel, penable, pwrite, paddr, req_done}, {2'b11, ew, ea, 4'b0000});
      if (ew) check("access_pwdata", pwdata, ed);
      pready = !abort_xfer && (k == waits);
      prdata = (k == waits) ? rdv : DW'($urandom);
      tick();
      pready = 1'b0;
    end
    check("done_onehot", req_done, 32'd1 << g);
    check("done_err", {31'd0, req_err}, {31'd0, abort_xfer});
    check("done_rdata", req_rdata, (ew || abort_xfer) ? 32'd0 : {24'd0, rdv});
    check("done_bus_idle", {psel, penable}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    int prev_g;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] elig;

    rst    = 1'b1;
    pready = 1'b0;
    prdata = '0;
    m_req  = '0;
    m_wr   = '0;
    for (int i = 0; i < NREQ; i++) begin
      m_addr[i]  = '0;
      m_wdata[i] = '0;
    end
    drive();
    ptr_m = 0;
    #2 rst = 1'b0;
    tick();
    tick();
    check("reset_outputs", {psel, penable, pwrite, paddr, pwdata, req_done, req_err, req_rdata}, 0);
    rst = 1'b1;
    tick();

    // Single write from requester 2, zero wait states
    m_req = 4'b0100; m_wr[2] = 1'b1; m_addr[2] = 4'h5; m_wdata[2] = 8'hA3;
    drive();
    tick();
    check("latency_setup", {psel, penable}, 2'b10);
    serve(2, 0, 1'b0, 1'b0, 8'h00);
    m_req = '0;
    drive();

    // Read from requester 0 with three wait states
    m_req = 4'b0001; m_wr[0] = 1'b0; m_addr[0] = 4'h9;
    drive();
    serve(0, 3, 1'b0, 1'b0, 8'h3C);
    m_req = '0;
    drive();

    // Requester 1 keeps req high through its completion
    m_req = 4'b0010; m_wr[1] = 1'b0; m_addr[1] = 4'h7;
    drive();
    serve(1, 1, 1'b0, 1'b0, 8'h5E);
    tick();
    check("masked_after_done", {31'd0, psel}, 0);
    tick();
    check("regrant_setup", {psel, penable, paddr}, {2'b10, 4'h7});
    serve(1, 0, 1'b0, 1'b0, 8'hC1);
    m_req = '0;
    drive();
    tick();

    // Reset in the middle of ACCESS for requester 2
    m_req = 4'b0100; m_wr[2] = 1'b1; m_addr[2] = 4'hC; m_wdata[2] = 8'h5A;
    drive();
    tick();
    check("rst_pre_setup", {psel, penable}, 2'b10);
    tick();
    check("rst_pre_access", {psel, penable}, 2'b11);
    #3 rst = 1'b0;
    #1;
    check("rst_async_zero", {psel, penable, pwrite, paddr, pwdata, req_done, req_err, req_rdata}, 0);
    m_req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      m_wr[i]    = 1'($urandom);
      m_addr[i]  = AW'($urandom);
      m_wdata[i] = DW'($urandom);
    end
    drive();
    tick();
    check("rst_hold_quiet", {psel, req_done}, 0);
    tick();
    check("rst_hold_quiet", {psel, req_done}, 0);
    rst   = 1'b1;
    ptr_m = 0;

    // All four requesting continuously: strict rotation from 0
    for (int r = 0; r < 5; r++) begin
      serve(r % NREQ, r % 2, 1'b0, 1'b0, DW'($urandom));
    end
    m_req = '0;
    drive();
    tick();

    // Randomized traffic against the round-robin model
    prev_g = -1;
    for (int r = 0; r < 40; r++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      m_req = mask;
      for (int i = 0; i < NREQ; i++) begin
        m_wr[i]    = 1'($urandom);
        m_addr[i]  = AW'($urandom);
        m_wdata[i] = DW'($urandom);
      end
      drive();
      elig = mask;
      if (prev_g >= 0) elig = mask & ~(NREQ'(1) << prev_g);
      if (elig == '0) elig = mask;
      g = next_grant(elig, ptr_m);
      serve(g, $urandom_range(0, 4), 1'b0, 1'($urandom), DW'($urandom));
      prev_g = g;
    end
    m_req = '0;
    drive();
    tick();

`ifdef APB_TIMEOUT_EN
    // pready held low: abort after TIMEOUT ACCESS cycles
    m_req = 4'b0001; m_wr[0] = 1'b0; m_addr[0] = 4'h2;
    drive();
    g = next_grant(m_req, ptr_m);
    serve(g, 0, 1'b1, 1'b0, 8'h00);
    m_req = '0;
    drive();
    tick();
    // pready rising in the last allowed cycle wins over the timeout
    m_req = 4'b0001;
    drive();
    g = next_grant(m_req, ptr_m);
    serve(g, TIMEOUT - 1, 1'b0, 1'b0, 8'h77);
    m_req = '0;
    drive();
    tick();
`endif

    tick();
    check("final_idle", {psel, penable, req_done, req_err}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Round-robin APB master that lets NREQ local requesters share one APB slave port.
- Picks one requester at a time and drives the APB SETUP/ACCESS phases for it.
- Waits out pready wait states, then returns completion and read data to that requester.
- Sits between the local initiators and the APB slave; the slave's psel, penable, pwrite, paddr and pwdata come only from this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 4, APB address width.
- DW, 8, APB data width.
- TIMEOUT, 16, maximum pready-low cycles in ACCESS before abort. Used only with APB_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- req  in  NREQ  per-requester transfer request.
- req_write  in  NREQ  per-requester direction: 1 = write, 0 = read.
- req_addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW].
- req_done  out  NREQ  one-hot, one-cycle completion pulse.
- req_err  out  1  valid while req_done is high; 1 = transfer aborted.
- req_rdata  out  DW  read data, valid while req_done is high (read transfers).
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  AW  APB address.
- pwdata  out  DW  APB write data.
- pready  in  1  slave ready.
- prdata  in  DW  slave read data.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs go to 0 immediately.
  - State goes to IDLE and the round-robin pointer goes to 0.
  - A transfer in flight is abandoned with no req_done.
  - Operation resumes on the first rising clk edge after rst goes high.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - psel = 0, penable = 0.
  - Eligible requesters: req & ~req_done. This masks the requester completed in the previous cycle.
  - If any requester is eligible, grant g is the first eligible index searching upward from the pointer, wrapping modulo NREQ.
  - On that edge: register paddr, pwdata and pwrite from requester g; store g; set pointer = (g+1) mod NREQ; go to SETUP.
- SETUP: psel = 1, penable = 0. Go to ACCESS unconditionally.
- ACCESS:
  - psel = 1, penable = 1; paddr, pwdata and pwrite held stable.
  - If pready is low, stay in ACCESS.
  - If pready is high at a clk edge:
    - req_done[g] = 1 for the next cycle, req_err = 0.
    - On a read, req_rdata captures prdata on that edge; on a write, req_rdata = 0.
    - psel and penable drop to 0; go to IDLE.
- No back-to-back transfers: at least one IDLE cycle between transfers, so at least 3 cycles per transfer.
- Latency: req sampled high in IDLE at edge N gives SETUP in cycle N+1 and ACCESS in N+2. With zero wait states, req_done is high in cycle N+3.
- Requester handshake:
  - A requester holds req, req_write, req_addr and req_wdata stable until it sees its req_done.
  - It drops req on the edge after req_done, or keeps req high to request again; it is then eligible from the cycle after req_done.
  - Changes to a granted requester's inputs after grant have no effect; values are already registered.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,3,0 and so on.
- req_done, req_err and req_rdata return to 0 in every cycle without a completion.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With the macro defined:
  - A wait counter clears on entry to ACCESS and increments on each ACCESS cycle with pready low.
  - When the counter reaches TIMEOUT, the transfer aborts: req_done[g] = 1 and req_err = 1 for one cycle, req_rdata = 0, go to IDLE.
  - If pready is high in the same cycle the counter reaches TIMEOUT, pready wins and the transfer completes normally.
- Without the macro: ACCESS waits indefinitely, req_err is tied to 0, and no counter is built.

Decomposition:
- Shared package apb_ctrl_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS);
  - default AW/DW constants;
  - the default TIMEOUT constant.
- One sub-module, rr_arbiter: combinational grant given request vector and pointer; outputs one-hot grant, grant index and any-valid.
- The FSM, APB registers and timeout counter live in apb_rr_master.

Test Plan:
- Single write: req[2]=1, write, addr 4'h5, wdata 8'hA3, pready=1 -> paddr=5, pwdata=A3, pwrite=1 through SETUP and ACCESS; req_done=4'b0100 in cycle N+3; req_err=0.
- Read with 3 wait states: req[0]=1, read, addr 4'h9, pready low 3 ACCESS cycles, then high with prdata 8'h3C -> penable high 4 cycles; req_done[0] with req_rdata=3C.
- All four requesters requesting continuously -> grant order 0,1,2,3,0; pointer wraps; no requester granted twice before the others.
- Reset mid-ACCESS: assert rst low between clk edges -> psel, penable and all outputs 0 immediately; no req_done; after release, pointer=0 and requester 0 is served first.
- Requester keeps req high through req_done -> not granted in the IDLE cycle right after req_done; granted in the next arbitration if eligible and first from the pointer.
- APB_TIMEOUT_EN, TIMEOUT=16, pready held low -> req_done and req_err high together after 16 ACCESS cycles, then IDLE. Repeat with pready rising on the 16th cycle -> normal completion, req_err=0.
